loopback_fifo_xfrm: RTL

//  Parametrised successor to the plain CDC loopback application. It sits between the usb_cdc
//  OUT-endpoint stream and the IN-endpoint stream on the application clock. A DEPTH-entry FIFO

---
 rtl/loopback_fifo_xfrm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/loopback_fifo_xfrm.sv
// USB CDC loopback: OUT-endpoint bytes are transformed on write into a show-ahead FIFO
// and replayed on the IN endpoint, optionally gated into bursts.
module loopback_fifo_xfrm #(
    parameter int BIT_WIDTH   = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int BURST_LEN   = 8,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [BIT_WIDTH-1:0]  out_data_i,
    input  logic                  out_valid_i,
    output logic                  out_ready_o,
    output logic [BIT_WIDTH-1:0]  in_data_o,
    output logic                  in_valid_o,
    input  logic                  in_ready_i,
    input  logic [1:0]            mode_i,
    input  logic                  flush_i,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [15:0]           rx_count_o,
    output logic [15:0]           tx_count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int TMR_W = $clog2(IDLE_CYCLES) + 1;

    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] BURST_LVL  = LVL_W'(BURST_LEN);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(IDLE_CYCLES - 1);
    localparam logic [1:0]       MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN
    } burst_state_t;

    logic [BIT_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]      level_reg, level_next;
    logic [15:0]           rx_count_reg, tx_count_reg;
    logic [TMR_W-1:0]      timer_reg, timer_next;
    burst_state_t          state_reg, state_next;

    logic                  wr_en;
    logic                  rd_en;
    logic [BIT_WIDTH-1:0]  wr_data_xf;

    // Ready looks only at registered level, so a read never raises it in the same cycle.
    assign out_ready_o = (level_reg != FULL_LVL) && !flush_i;
    assign wr_en       = out_valid_i && out_ready_o;

    assign in_valid_o  = !flush_i && (level_reg != '0) &&
                         ((mode_i != MODE_BURST) || (state_reg == ST_DRAIN));
    assign rd_en       = in_valid_o && in_ready_i;
    assign in_data_o   = mem[rd_ptr_reg];

    assign level_o     = level_reg;
    assign rx_count_o  = rx_count_reg;
    assign tx_count_o  = tx_count_reg;

    always_comb begin
        wr_data_xf = out_data_i;
        case (mode_i)
            2'd1:    wr_data_xf = ~out_data_i;
            2'd2:    wr_data_xf = out_data_i + BIT_WIDTH'(1);
            default: wr_data_xf = out_data_i;
        endcase
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (wr_en) wr_ptr_next = wr_ptr_reg + DEPTH_LOG2'(1);
            if (rd_en) rd_ptr_next = rd_ptr_reg + DEPTH_LOG2'(1);
            case ({wr_en, rd_en})
                2'b10:   level_next = level_reg + LVL_W'(1);
                2'b01:   level_next = level_reg - LVL_W'(1);
                default: level_next = level_reg;
            endcase
        end
    end

    // The idle timeout compares the post-edge timer value, so the release edge is the
    // (IDLE_CYCLES-1)th write-free edge after the last accepted byte.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        if (flush_i || (mode_i != MODE_BURST)) begin
            state_next = ST_IDLE;
            timer_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    timer_next = '0;
                    if (wr_en) state_next = ST_COLLECT;
                end
                ST_COLLECT: begin
                    timer_next = wr_en ? '0 : timer_reg + TMR_W'(1);
                    if ((level_next >= BURST_LVL) || (timer_next == TMR_LAST))
                        state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    timer_next = '0;
                    if (level_next == '0) state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            rx_count_reg <= '0;
            tx_count_reg <= '0;
            timer_reg    <= '0;
            state_reg    <= ST_IDLE;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            timer_reg    <= timer_next;
            state_reg    <= state_next;
            if (wr_en) rx_count_reg <= rx_count_reg + 16'd1;
            if (rd_en) tx_count_reg <= tx_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i && wr_en) mem[wr_ptr_reg] <= wr_data_xf;
    end

endmodule
